dp_pool_window: RTL and testbench
=================================

DP_POOL_WINDOW -- requirements
Module: dp_pool_window

Interface
- REQ-001 Parameter: DATA_WIDTH, 32, input beat width in bits; multiple of WORD_WIDTH.
- REQ-002 Parameter: WORD_WIDTH, 8, element width in bits; lanes L = DATA_WIDTH/WORD_WIDTH.
- REQ-003 Parameter: WINDOW_BEATS, 2, input beats per pooling window; ≥1; L*WINDOW_BEATS a power of two.
- REQ-004 Parameter: SIGNED, 0, 1 = elements two's-complement, 0 = unsigned.
- REQ-005 Ports, one per line:
  - clk_i, in, 1, sole clock, rising edge.
  - rst_i, in, 1, synchronous active-high reset.
  - clear_i, in, 1, abandons the current partial window.
  - mode_i, in, 1, 0 = max, 1 = average.
  - mat_i, hwpe_stream_intf_stream.sink, DATA_WIDTH, element stream.
  - res_o, hwpe_stream_intf_stream.source, WORD_WIDTH, one pooled element per window.
  - busy_o, out, 1, high while a window is partially accumulated or a result is held.

Function
- REQ-006 Handshakes are valid & ready; the data of a beat is consumed only on a mat_i handshake.
- REQ-007 FSM states ACC and FULL. ACC -> FULL on the handshake of beat WINDOW_BEATS-1. FULL -> ACC on a res_o handshake.
- REQ-008 mat_i.ready = (state==ACC) | res_o.ready; res_o.valid = (state==FULL); res_o.strb all ones.
- REQ-009 In FULL, a res_o handshake coinciding with a final-beat handshake shall stay in FULL with the new result. A non-final beat in that cycle shall go to ACC with the new partial state.
- REQ-010 The beat counter counts 0..WINDOW_BEATS-1, increments per mat_i handshake and wraps to 0 on the final beat.
- REQ-011 mode_i is sampled on beat 0 of each window and held for that window; changes mid-window are ignored.
- REQ-012 Max mode: result = maximum of all L*WINDOW_BEATS elements, compared per SIGNED. The running max is initialised from beat 0's lanes, not from zero.
- REQ-013 Average mode: the accumulator has WORD_WIDTH+log2(L*WINDOW_BEATS) bits, sign- or zero-extended per SIGNED. Result = sum arithmetic-shifted right by log2(L*WINDOW_BEATS), i.e. truncation toward minus infinity; no overflow is possible.
- REQ-014 Latency: res_o.valid rises the cycle after the final-beat handshake. res_o.data stays stable while valid & !ready.
- REQ-015 clear_i (ACC state) zeroes the counter and accumulator next cycle and does not assert res_o.valid. A beat presented in the same cycle is accepted and discarded.
- REQ-016 clear_i in FULL shall not drop the held result; it clears only any partial state.
- REQ-017 WINDOW_BEATS==1 shall produce one result per beat at full throughput when res_o.ready is held high.
- REQ-018 busy_o = (counter!=0) | (state==FULL).

Reset
- REQ-019 rst_i high at a clock edge forces: state ACC, counter 0, accumulator 0, res_o.valid 0, res_o.data 0, busy_o 0.
- REQ-020 Reset mid-window or with a result held discards all data; the first beat after reset starts a new window.
- REQ-021 rst_i dominates clear_i and all handshakes in the same cycle.

Configuration
- REQ-022 Macro DP_POOL_AVG_EN. Defined: average mode and its accumulator are present per REQ-013. Undefined: mode_i is ignored, max mode only, and no sum accumulator is synthesised.

Verification (L=4, WORD_WIDTH=8, WINDOW_BEATS=2, SIGNED=0 unless noted)
- REQ-023 Max: beats 0x01020304, 0x05FF0607, ready=1 -> res 0xFF one cycle after beat 1; busy_o then 0.
- REQ-024 Average: beats 0x10101010, 0x20202020 -> res 0x18. Beats 0x01010101, 0x00000000 -> res 0x00 (truncation).
- REQ-025 SIGNED=1 max: beats 0xFEFEFEFE, 0x80FF8081 -> res 0xFF (-1).
- REQ-026 Backpressure: res_o.ready=0 for 5 cycles after a result -> data stable, mat_i.ready=0. Then ready=1 with the next window's final beat -> back-to-back results, no loss.
- REQ-027 clear_i asserted after beat 0 of 0xFFFFFFFF, then beats 0x01010101, 0x02020202 -> single result 0x02 in max mode.
- REQ-028 rst_i asserted while FULL -> res_o.valid 0 next cycle; the next two beats form a fresh window.

Source files
------------

// File: rtl/dp_pool_window_if.sv
// Valid/ready element stream carrying DATA_WIDTH bits plus byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk
);
  logic                            valid;
  logic                            ready;
  logic [DATA_WIDTH-1:0]           data;
  logic [(DATA_WIDTH+7)/8-1:0]     strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/dp_pool_window.sv
// Max/average pooling of L lanes over WINDOW_BEATS beats into one element.
// Average mode and its sum accumulator exist only with DP_POOL_AVG_EN defined.
module dp_pool_lane #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ACC_W      = 11,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic [WORD_WIDTH-1:0] elem,
`ifdef DP_POOL_AVG_EN
  output logic [ACC_W-1:0]      ext,
`endif
  output logic [WORD_WIDTH-1:0] key
);
  // Flipping the MSB maps two's-complement order onto unsigned order.
  localparam logic [WORD_WIDTH-1:0] FLIP = SIGNED ? {1'b1, {(WORD_WIDTH-1){1'b0}}} : '0;

  assign key = elem ^ FLIP;

`ifdef DP_POOL_AVG_EN
  if (SIGNED) begin : g_sext
    assign ext = ACC_W'($signed(elem));
  end else begin : g_zext
    assign ext = ACC_W'(elem);
  end
`endif
endmodule

module dp_pool_window #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned WINDOW_BEATS = 2,
  parameter bit          SIGNED       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  mode_i,
  hwpe_stream_intf_stream.sink   mat_i,
  hwpe_stream_intf_stream.source res_o,
  output logic                  busy_o
);
  localparam int unsigned L     = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned N     = L * WINDOW_BEATS;
  localparam int unsigned SHIFT = $clog2(N);
  localparam int unsigned ACC_W = WORD_WIDTH + SHIFT;
  localparam int unsigned CNT_W = (WINDOW_BEATS > 1) ? $clog2(WINDOW_BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(WINDOW_BEATS - 1);
  localparam logic [WORD_WIDTH-1:0] FLIP = SIGNED ? {1'b1, {(WORD_WIDTH-1){1'b0}}} : '0;

  typedef enum logic {ACC, FULL} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]        max_q, res_q, res_d;
  logic [WORD_WIDTH-1:0]        beat_max, run_max;
  logic [L-1:0][WORD_WIDTH-1:0] lane_elem, lane_key;
  logic                         mat_ready, res_valid;
  logic                         mat_hs, res_hs, first_beat, last_beat, take, load_res;
  logic                         unused_strb;
`ifdef DP_POOL_AVG_EN
  logic [L-1:0][ACC_W-1:0]      lane_ext;
  logic [ACC_W-1:0]             sum_q, beat_sum, run_sum;
  logic                         mode_q, mode_cur;
`else
  logic                         unused_mode;
`endif

  assign lane_elem   = mat_i.data;
  assign unused_strb = ^mat_i.strb;

  for (genvar i = 0; i < L; i++) begin : g_lane
    dp_pool_lane #(
      .WORD_WIDTH (WORD_WIDTH),
      .ACC_W      (ACC_W),
      .SIGNED     (SIGNED)
    ) u_lane (
      .elem (lane_elem[i]),
`ifdef DP_POOL_AVG_EN
      .ext  (lane_ext[i]),
`endif
      .key  (lane_key[i])
    );
  end

  always_comb begin
    beat_max = lane_key[0];
    for (int i = 1; i < L; i++)
      if (lane_key[i] > beat_max) beat_max = lane_key[i];
  end

  assign mat_hs     = mat_i.valid & mat_ready;
  assign res_hs     = res_valid & res_o.ready;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);
  // clear_i still lets the beat handshake, but its data never lands.
  assign take       = mat_hs & ~clear_i;
  assign load_res   = take & last_beat;
  assign run_max    = (first_beat || beat_max > max_q) ? beat_max : max_q;

`ifdef DP_POOL_AVG_EN
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < L; i++) beat_sum = beat_sum + lane_ext[i];
  end

  assign run_sum  = first_beat ? beat_sum : sum_q + beat_sum;
  assign mode_cur = first_beat ? mode_i : mode_q;
  // Dropping the low SHIFT bits is a floor divide; the top bits fit the word.
  assign res_d    = mode_cur ? run_sum[SHIFT +: WORD_WIDTH] : (run_max ^ FLIP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      mode_q <= 1'b0;
    end else if (clear_i) begin
      sum_q  <= '0;
    end else if (mat_hs) begin
      sum_q <= run_sum;
      if (first_beat) mode_q <= mode_i;
    end
  end
`else
  assign unused_mode = mode_i;
  assign res_d       = run_max ^ FLIP;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (mat_hs) cnt_d = last_beat ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      max_q <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clear_i)   max_q <= '0;
      else if (take) max_q <= run_max;
      if (load_res)  res_q <= res_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ACC;
    else       state_q <= state_d;
  end

  // A fresh final beat wins over draining, so FULL can re-arm in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (load_res) state_d = FULL;
      FULL:    if (load_res) state_d = FULL;
               else if (res_hs) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    mat_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ACC:  mat_ready = 1'b1;
      FULL: begin
        mat_ready = res_o.ready;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign mat_i.ready = mat_ready;
  assign res_o.valid = res_valid;
  assign res_o.data  = res_q;
  assign res_o.strb  = '1;
  assign busy_o      = (cnt_q != '0) | (state_q == FULL);
endmodule

// File: tb/tb_dp_pool_window.sv
// Directed bench: unsigned, signed and single-beat-window pool instances share one stimulus.
module tb_dp_pool_window;
  logic        clk = 1'b0;
  logic        rst, clear, mode, mat_valid, res_ready;
  logic [31:0] mat_data;
  logic        busy_u, busy_s, busy_w;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) mat_u (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(8))  res_u (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) mat_s (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(8))  res_s (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) mat_w (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(8))  res_w (.clk(clk));

  assign mat_u.valid = mat_valid; assign mat_u.data = mat_data; assign mat_u.strb = '1;
  assign mat_s.valid = mat_valid; assign mat_s.data = mat_data; assign mat_s.strb = '1;
  assign mat_w.valid = mat_valid; assign mat_w.data = mat_data; assign mat_w.strb = '1;
  assign res_u.ready = res_ready;
  assign res_s.ready = res_ready;
  assign res_w.ready = res_ready;

  dp_pool_window #(.DATA_WIDTH(32), .WORD_WIDTH(8), .WINDOW_BEATS(2), .SIGNED(1'b0)) dut_u (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .mat_i(mat_u), .res_o(res_u), .busy_o(busy_u));
  dp_pool_window #(.DATA_WIDTH(32), .WORD_WIDTH(8), .WINDOW_BEATS(2), .SIGNED(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .mat_i(mat_s), .res_o(res_s), .busy_o(busy_s));
  dp_pool_window #(.DATA_WIDTH(32), .WORD_WIDTH(8), .WINDOW_BEATS(1), .SIGNED(1'b0)) dut_w (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .mat_i(mat_w), .res_o(res_w), .busy_o(busy_w));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d);
    mat_valid = 1'b1;
    mat_data  = d;
    tick();
    mat_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 1'b0; mat_valid = 1'b0; res_ready = 1'b1; mat_data = '0;
    tick(); tick();
    chk("rst_valid", res_u.valid, 0);
    chk("rst_data",  res_u.data, 0);
    chk("rst_busy",  busy_u, 0);
    chk("rst_ready", mat_u.ready, 1);
    rst = 1'b0;

    // max, unsigned vs signed interpretation of the same beats
    send(32'h01020304);
    chk("max_b0_busy",  busy_u, 1);
    chk("max_b0_valid", res_u.valid, 0);
    send(32'h05FF0607);
    chk("max_valid", res_u.valid, 1);
    chk("max_data",  res_u.data, 32'hFF);
    chk("smax_data", res_s.data, 32'h07);
    tick();
    chk("max_drain_valid", res_u.valid, 0);
    chk("max_drain_busy",  busy_u, 0);

    send(32'hFEFEFEFE);
    send(32'h80FF8081);
    chk("smax_neg", res_s.data, 32'hFF);
    chk("umax_neg", res_u.data, 32'hFF);
    tick();

`ifdef DP_POOL_AVG_EN
    mode = 1'b1; send(32'h10101010);
    mode = 1'b0; send(32'h20202020);
    chk("avg_data",  res_u.data, 32'h18);
    chk("savg_data", res_s.data, 32'h18);
    tick();
    mode = 1'b1; send(32'h01010101); send(32'h00000000);
    chk("avg_trunc", res_u.data, 32'h00);
    tick();
    mode = 1'b1; send(32'hFFFFFFFF);
    mode = 1'b0; send(32'hFFFFFFFE);
    chk("avg_u_ff", res_u.data, 32'hFE);
    chk("avg_s_neg", res_s.data, 32'hFE);
    tick();
`else
    mode = 1'b1; send(32'h10101010); send(32'h20202020);
    chk("nomode_max", res_u.data, 32'h20);
    tick();
`endif
    mode = 1'b0;

    // backpressure holds result and stalls input
    res_ready = 1'b0;
    send(32'h01020304); send(32'h05FF0607);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", res_u.valid, 1);
      chk("bp_data",  res_u.data, 32'hFF);
      chk("bp_ready", mat_u.ready, 0);
      tick();
    end
    res_ready = 1'b1;
    send(32'h11111111);
    chk("bp_rel_valid", res_u.valid, 0);
    chk("bp_rel_busy",  busy_u, 1);
    send(32'h22222222);
    chk("bp_next", res_u.data, 32'h22);
    send(32'h33333333);
    chk("bb_gap_valid", res_u.valid, 0);
    send(32'h30303030);
    chk("bb_data", res_u.data, 32'h33);
    tick();
    chk("bb_drain", res_u.valid, 0);

    // clear abandons partial windows, including a beat in the clear cycle
    send(32'hFFFFFFFF);
    chk("clr_pre_busy", busy_u, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_busy", busy_u, 0);
    clear = 1'b1; send(32'h09090909); clear = 1'b0;
    chk("clr_beat_busy", busy_u, 0);
    send(32'h01010101);
    chk("clr_b0_valid", res_u.valid, 0);
    send(32'h02020202);
    chk("clr_valid", res_u.valid, 1);
    chk("clr_data",  res_u.data, 32'h02);
    tick();

    // clear while a result is held keeps it
    res_ready = 1'b0;
    send(32'h01020304); send(32'h05FF0607);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_full_valid", res_u.valid, 1);
    chk("clr_full_data",  res_u.data, 32'hFF);

    // reset with result held, then mid-window
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_full_valid", res_u.valid, 0);
    chk("rst_full_data",  res_u.data, 0);
    chk("rst_full_busy",  busy_u, 0);
    res_ready = 1'b1;
    send(32'hFFFFFFFF);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_busy", busy_u, 0);
    send(32'h04040404);
    chk("rst_new_b0", res_u.valid, 0);
    send(32'h03030303);
    chk("rst_new_data", res_u.data, 32'h04);
    tick();

    // single-beat windows stream at full rate
    send(32'h01020304);
    chk("w1_valid0", res_w.valid, 1);
    chk("w1_data0",  res_w.data, 32'h04);
    chk("w1_ready",  mat_w.ready, 1);
    send(32'h0A000000);
    chk("w1_data1", res_w.data, 32'h0A);
    send(32'h00000055);
    chk("w1_data2", res_w.data, 32'h55);
    tick();
    chk("w1_drain", res_w.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
